// File: rtl/ipm_reg_fifo_v2_0.sv
// rtl/ipm_reg_fifo_v2_0.sv - parametrised register FIFO with valid/ready on both sides
//
// Small elastic buffer between streaming pipeline stages, built from flops
// only (no RAM macro). DEPTH can be any integer >= 2. The pointers wrap by
// compare, so a non-power-of-two depth does not waste or alias entries.
//
// Optional feature macro: IPM_REG_FIFO_BYPASS_EN
//   defined   : combinational fall-through when empty. An incoming word is
//               shown on data_out in the same cycle. If the sink accepts it,
//               the word is never stored.
//   undefined : outputs come only from registers, so the minimum
//               write-to-valid latency is 1 cycle.
//
// Parameters:
//   W       data width in bits
//   DEPTH   number of entries
//   AF_LVL  almost_full  when count >= AF_LVL
//   AE_LVL  almost_empty when count <= AE_LVL
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   flush           synchronous clear of pointers and count (storage kept)
//   data_in_valid   write request
//   data_in         write data
//   data_in_ready   space available (~full)
//   data_out_ready  read accept
//   data_out        head-of-queue data
//   data_out_valid  head entry valid (~empty)
//   count           occupancy, 0..DEPTH
//   almost_full     count >= AF_LVL
//   almost_empty    count <= AE_LVL

module ipm_reg_fifo_v2_0 #(
    parameter  int W      = 8,
    parameter  int DEPTH  = 4,
    parameter  int AF_LVL = 3,
    parameter  int AE_LVL = 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          data_in_valid,
    input  logic [W-1:0]  data_in,
    output logic          data_in_ready,
    input  logic          data_out_ready,
    output logic [W-1:0]  data_out,
    output logic          data_out_valid,
    output logic [CW-1:0] count,
    output logic          almost_full,
    output logic          almost_empty
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LVL);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;

    logic          fifo_empty;
    logic          fifo_full;
    logic          wr_fire;
    logic          rd_fire;
    logic          pass_thru;
    logic          do_wr;
    logic          do_rd;

    assign fifo_empty = (cnt == '0);
    assign fifo_full  = (cnt == FULL_CNT);

    // Ready depends only on the registered count. This keeps the two sides
    // free of combinational paths to each other, so a full FIFO cannot
    // accept a word in the same cycle that it is read.
    assign data_in_ready = ~fifo_full;

`ifdef IPM_REG_FIFO_BYPASS_EN
    logic bypass_hit;

    // When empty, present the incoming word directly. If the sink takes it
    // in the same cycle, the write and the read cancel and nothing is stored.
    assign bypass_hit     = fifo_empty & data_in_valid;
    assign pass_thru      = bypass_hit & data_out_ready;
    assign data_out_valid = ~fifo_empty | bypass_hit;
    assign data_out       = bypass_hit ? data_in : mem[rptr];
`else
    assign pass_thru      = 1'b0;
    assign data_out_valid = ~fifo_empty;
    assign data_out       = mem[rptr];
`endif

    assign wr_fire = data_in_valid & data_in_ready;
    assign rd_fire = data_out_valid & data_out_ready;

    // A pass-through word touches neither the pointers nor the count.
    assign do_wr = wr_fire & ~pass_thru;
    assign do_rd = rd_fire & ~pass_thru;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Pointers and occupancy. Flush wins over any handshake in its cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_wr) begin
                wptr <= ptr_inc(wptr);
            end
            if (do_rd) begin
                rptr <= ptr_inc(rptr);
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage. Reset clears it. Flush leaves it alone, because only the
    // pointers decide what is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr && !flush) begin
            mem[wptr] <= data_in;
        end
    end

    assign count        = cnt;
    assign almost_full  = (cnt >= AF_CNT);
    assign almost_empty = (cnt <= AE_CNT);

endmodule

// File: tb/tb_ipm_reg_fifo_v2_0.sv
// tb/tb_ipm_reg_fifo_v2_0.sv - self-checking bench for ipm_reg_fifo_v2_0 (DEPTH 4 and DEPTH 3)

module tb_ipm_reg_fifo_v2_0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       vin;
    logic [7:0] din;
    logic       ordy;

    logic       rdy4, val4, af4, ae4;
    logic [7:0] dout4;
    logic [2:0] cnt4;
    logic       rdy3, val3, af3, ae3;
    logic [7:0] dout3;
    logic [1:0] cnt3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ipm_reg_fifo_v2_0 #(.W(8), .DEPTH(4), .AF_LVL(3), .AE_LVL(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .data_in_valid(vin), .data_in(din), .data_in_ready(rdy4),
        .data_out_ready(ordy), .data_out(dout4), .data_out_valid(val4),
        .count(cnt4), .almost_full(af4), .almost_empty(ae4)
    );

    ipm_reg_fifo_v2_0 #(.W(8), .DEPTH(3), .AF_LVL(2), .AE_LVL(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .data_in_valid(vin), .data_in(din), .data_in_ready(rdy3),
        .data_out_ready(ordy), .data_out(dout3), .data_out_valid(val3),
        .count(cnt3), .almost_full(af3), .almost_empty(ae3)
    );

    // Behavioural model: one queue per DUT, holding the words not yet read.
    logic [7:0] mq [2][$];
    int depth_m [2] = '{4, 3};
    int af_m    [2] = '{3, 2};
    int ae_m    [2] = '{1, 1};

`ifdef IPM_REG_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || flush) begin
                mq[k].delete();
            end else if (BYP && mq[k].size() == 0 && vin && ordy) begin
                // word passes straight through, nothing stored
            end else begin
                bit wr, rd;
                wr = vin && (mq[k].size() != depth_m[k]);
                rd = (mq[k].size() != 0) && ordy;
                if (rd) void'(mq[k].pop_front());
                if (wr) mq[k].push_back(din);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int sz, a_cnt;
            bit a_val, a_rdy, a_af, a_ae, e_val;
            logic [7:0] a_dat, e_dat;
            sz    = mq[k].size();
            a_cnt = (k == 0) ? int'(cnt4) : int'(cnt3);
            a_val = (k == 0) ? val4 : val3;
            a_rdy = (k == 0) ? rdy4 : rdy3;
            a_af  = (k == 0) ? af4 : af3;
            a_ae  = (k == 0) ? ae4 : ae3;
            a_dat = (k == 0) ? dout4 : dout3;
            e_val = (sz != 0) || (BYP && vin);
            e_dat = (sz != 0) ? mq[k][0] : din;
            chk($sformatf("model_count[d%0d]", depth_m[k]), a_cnt, sz);
            chk($sformatf("model_valid[d%0d]", depth_m[k]), int'(a_val), int'(e_val));
            chk($sformatf("model_ready[d%0d]", depth_m[k]), int'(a_rdy), int'(sz != depth_m[k]));
            chk($sformatf("model_af[d%0d]", depth_m[k]), int'(a_af), int'(sz >= af_m[k]));
            chk($sformatf("model_ae[d%0d]", depth_m[k]), int'(a_ae), int'(sz <= ae_m[k]));
            if (e_val) chk($sformatf("model_data[d%0d]", depth_m[k]), int'(a_dat), int'(e_dat));
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the edge.
    task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit f);
        vin = v; din = d; ordy = r; flush = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; vin = 1'b0; din = 8'h00; ordy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_count", int'(cnt4), 0);
        chk("rst_in_ready", int'(rdy4), 1);
        chk("rst_out_valid", int'(val4), 0);
        chk("rst_af", int'(af4), 0);
        chk("rst_ae", int'(ae4), 1);
        chk("rst_data_out", int'(dout4), 0);

        // Fill to full with the sink stalled
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
        chk("full_count", int'(cnt4), 4);
        chk("full_in_ready", int'(rdy4), 0);
        chk("full_af", int'(af4), 1);
        chk("full_data", int'(dout4), 8'h11);
        chk("d3_full_count", int'(cnt3), 3);

        // Read at full: 0x55 must not be taken in the same cycle
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        chk("rd_at_full_count", int'(cnt4), 3);
        chk("rd_at_full_ready", int'(rdy4), 1);
        chk("rd_at_full_head", int'(dout4), 8'h22);

        // Bring occupancy down to 2, then stream through the pointer wrap
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("cnt2_count", int'(cnt4), 2);
        for (int i = 0; i < 10; i++) begin
            int exp_head;
            exp_head = (i == 0) ? 8'h33 : (i == 1) ? 8'h44 : 8'h80 + i - 2;
            chk("stream_head", int'(dout4), exp_head);
            drive(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            chk("stream_count", int'(cnt4), 2);
        end
        chk("d3_stream_count", int'(cnt3), 1);

        // Flush at count 3 with a concurrent write
        drive(1'b1, 8'h8A, 1'b0, 1'b0);
        chk("pre_flush_count", int'(cnt4), 3);
        drive(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("flush_count", int'(cnt4), 0);
        chk("flush_valid", int'(val4), 0);
        chk("flush_ae", int'(ae4), 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("flush_word_lost", int'(val4), 0);

        // Asynchronous reset in the middle of a burst
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        chk("burst_count", int'(cnt4), 2);
        vin = 1'b0; din = 8'h00;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", int'(cnt4), 0);
        chk("async_rst_valid", int'(val4), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Empty FIFO, word offered with the sink ready
        vin = 1'b1; din = 8'hA5; ordy = 1'b1; flush = 1'b0;
        #2;
`ifdef IPM_REG_FIFO_BYPASS_EN
        chk("byp_same_valid", int'(val4), 1);
        chk("byp_same_data", int'(dout4), 8'hA5);
        chk("byp_same_count", int'(cnt4), 0);
`else
        chk("nobyp_same_valid", int'(val4), 0);
`endif
        @(posedge clk);
        #1;
`ifdef IPM_REG_FIFO_BYPASS_EN
        chk("byp_next_count", int'(cnt4), 0);
`else
        chk("nobyp_next_valid", int'(val4), 1);
        chk("nobyp_next_data", int'(dout4), 8'hA5);
        chk("nobyp_next_count", int'(cnt4), 1);
`endif
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_a5_count", int'(cnt4), 0);

        // Mixed traffic with a flush in the middle, checked by the model
        for (int i = 0; i < 60; i++) begin
            drive((i % 3) != 0, 8'(i) ^ 8'h5A, (i % 5) < 2, i == 40);
        end
        repeat (6) drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("final_count", int'(cnt4), 0);
        chk("final_d3_count", int'(cnt3), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
